// File: rtl/mmio_console_pkg.sv
// Shared register map and status helpers for the memory-mapped console peripheral.
// Offsets are byte addresses; the bus decode compares word indices (offset[7:2]).
package mmio_console_pkg;

    localparam logic [7:0] CONSOLE_HALT        = 8'h00;
    localparam logic [7:0] CONSOLE_CTRL        = 8'h04;
    localparam logic [7:0] CONSOLE_STATUS      = 8'h08;
    localparam logic [7:0] CONSOLE_TXDATA_BASE = 8'h10;

    localparam logic [5:0] HALT_WORD   = CONSOLE_HALT[7:2];
    localparam logic [5:0] CTRL_WORD   = CONSOLE_CTRL[7:2];
    localparam logic [5:0] STATUS_WORD = CONSOLE_STATUS[7:2];
    localparam logic [5:0] TXDATA_WORD = CONSOLE_TXDATA_BASE[7:2];

    typedef struct packed {
        logic overflow;
        logic full;
        logic empty;
    } chan_status_t;

    function automatic logic [7:0] status_byte(input chan_status_t s);
        return {5'b0, s};
    endfunction

endpackage

// File: rtl/mmio_console_sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter so full/empty never alias.
// A push while full is taken only when a pop happens in the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mmio_console.sv
// Memory-mapped console: per-channel TX FIFOs, status/irq registers and a sticky halt.
// Once halted, every bus write is ignored while reads and FIFO draining continue.
module mmio_console
    import mmio_console_pkg::*;
#(
    parameter  int CHANNELS = 2,
    parameter  int DEPTH    = 16,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_i,
    input  logic [3:0]            we_i,
    input  logic [7:0]            addr_i,
    input  logic [31:0]           data_i,
    output logic [31:0]           data_o,
    output logic [CHANNELS-1:0]   tx_valid_o,
    output logic [8*CHANNELS-1:0] tx_data_o,
    input  logic [CHANNELS-1:0]   tx_ready_i,
    output logic                  irq_o,
    output logic                  halt_o,
    output logic [7:0]            exit_code_o
);

    logic [5:0]          word_idx;
    logic                wr_ok, rd_req;
    logic                sel_halt, sel_ctrl, sel_status;

    logic [CHANNELS-1:0] ctrl_q, ctrl_d;
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic                halt_q, halt_d;
    logic [7:0]          exit_q, exit_d;
    logic                irq_q, irq_d;
    logic [31:0]         data_q, data_d;
    logic [31:0]         rd_data;

    logic [CHANNELS-1:0] push_req, pop, full, empty, empty_next, ovf_set;
    logic [CNT_W-1:0]    count [CHANNELS];
    logic [7:0]          head  [CHANNELS];

    assign word_idx   = addr_i[7:2];
    assign wr_ok      = en_i & (|we_i) & ~halt_q;
    assign rd_req     = en_i & (we_i == 4'b0000);
    assign sel_halt   = (word_idx == HALT_WORD);
    assign sel_ctrl   = (word_idx == CTRL_WORD);
    assign sel_status = (word_idx == STATUS_WORD);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        assign push_req[c] = wr_ok & we_i[0] & (word_idx == TXDATA_WORD + 6'(c));
        assign pop[c]      = ~empty[c] & tx_ready_i[c];
        assign ovf_set[c]  = push_req[c] & full[c] & ~pop[c];
        // DEPTH >= 2, so any push leaves the FIFO non-empty.
        assign empty_next[c] = ~push_req[c]
                             & (empty[c] | (pop[c] & (count[c] == CNT_W'(1))));

        assign tx_valid_o[c]      = ~empty[c];
        assign tx_data_o[8*c +: 8] = head[c];

        sync_fifo #(
            .WIDTH (8),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (push_req[c]),
            .pop_i   (tx_ready_i[c]),
            .data_i  (data_i[7:0]),
            .head_o  (head[c]),
            .count_o (count[c]),
            .full_o  (full[c]),
            .empty_o (empty[c])
        );
    end

    always_comb begin
        ctrl_d = ctrl_q;
        halt_d = halt_q;
        exit_d = exit_q;
        if (wr_ok && we_i[0] && sel_ctrl) begin
            ctrl_d = data_i[CHANNELS-1:0];
        end
        if (wr_ok && we_i[0] && sel_halt) begin
            halt_d = 1'b1;
            exit_d = data_i[7:0];
        end
        // A coincident overflow beats the W1C clear.
        for (int c = 0; c < CHANNELS; c++) begin
            ovf_d[c] = ovf_set[c]
                     | (ovf_q[c] & ~(wr_ok & sel_status & we_i[c] & data_i[8*c+2]));
        end
        irq_d = |(ctrl_d & empty_next);
    end

    always_comb begin
        rd_data = '0;
        if (sel_halt) begin
            rd_data = {23'b0, halt_q, exit_q};
        end else if (sel_ctrl) begin
            rd_data[CHANNELS-1:0] = ctrl_q;
        end else if (sel_status) begin
            for (int c = 0; c < CHANNELS; c++) begin
                rd_data[8*c +: 8] = status_byte('{overflow: ovf_q[c], full: full[c],
                                                  empty: empty[c]});
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (word_idx == TXDATA_WORD + 6'(c)) begin
                    rd_data = 32'(count[c]);
                end
            end
        end
        data_d = rd_req ? rd_data : 32'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= '0;
            ovf_q  <= '0;
            halt_q <= 1'b0;
            exit_q <= 8'h00;
            irq_q  <= 1'b0;
            data_q <= 32'b0;
        end else begin
            ctrl_q <= ctrl_d;
            ovf_q  <= ovf_d;
            halt_q <= halt_d;
            exit_q <= exit_d;
            irq_q  <= irq_d;
            data_q <= data_d;
        end
    end

    assign data_o      = data_q;
    assign irq_o       = irq_q;
    assign halt_o      = halt_q;
    assign exit_code_o = exit_q;

endmodule
